// File: rtl/goertzel_pkg.sv
// Shared types and constants for the multi-bin Goertzel detector.
package goertzel_pkg;

    localparam int unsigned FB = 40;  // fractional bits of Q24.40
    localparam int unsigned AW = 64;  // accumulator / coefficient width

    typedef logic signed [AW-1:0] q_t;

    typedef enum logic [2:0] {
        StIdle,
        StIter,
        StFRe,
        StFIm,
        StPRe,
        StPIm,
        StOut
    } state_e;

endpackage

// File: rtl/goertzel_multibin_mult_sign.sv
// Full-precision signed multiplier shared by every datapath step of the detector.
module mult_sign
    import goertzel_pkg::*;
#(
    parameter int unsigned W = AW
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/goertzel_multibin.sv
// Streaming multi-bin Goertzel detector with one time-shared multiplier.
// Define GOERTZEL_SAT_EN to clamp powers of 2^32 or more and flag them on m_sat.
module goertzel_multibin
    import goertzel_pkg::*;
#(
    parameter int unsigned NB = 4,
    parameter int unsigned NS = 1000,
    parameter int unsigned DW = 32,
    parameter int unsigned BW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coef_we,
    input  logic [BW-1:0]        coef_addr,
    input  logic signed [AW-1:0] coef_alpha,
    input  logic signed [AW-1:0] coef_cos,
    input  logic signed [AW-1:0] coef_sin,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BW-1:0]        m_bin,
    output logic [31:0]          m_power,
    output logic                 m_sat
);

    localparam int unsigned SW = $clog2(NS);
    localparam int unsigned PW = 2 * AW;
    localparam int unsigned IL = 2 * FB;  // lsb of the integer part of a squared value

    state_e        state_q, state_d;
    logic [BW-1:0] bin_q;
    logic [SW-1:0] samp_q;

    q_t alpha_q [NB];
    q_t cos_q   [NB];
    q_t sin_q   [NB];
    q_t v1_q    [NB];
    q_t v2_q    [NB];

    q_t             x_q, re_q, im_q;
    logic [PW-1:0]  acc_q;
    logic [31:0]    m_power_q;

    q_t               op_a, op_b, prod_q;
    logic signed [PW-1:0] prod;
    logic [PW-1:0]    pwr_sum;
    logic             last_bin, last_samp;
    logic             unused_pwr;

    assign last_bin   = (bin_q == BW'(NB - 1));
    assign last_samp  = (samp_q == SW'(NS - 1));
    assign prod_q     = prod[FB+AW-1:FB];
    assign pwr_sum    = acc_q + prod;
    assign unused_pwr = ^{pwr_sum[PW-1:IL+32], pwr_sum[IL-1:0]};

    // Operand selection: the state decides which product the single multiplier forms.
    always_comb begin
        op_a = '0;
        op_b = '0;
        unique case (state_q)
            StIter: begin op_a = alpha_q[bin_q]; op_b = v1_q[bin_q]; end
            StFRe:  begin op_a = cos_q[bin_q];   op_b = v1_q[bin_q]; end
            StFIm:  begin op_a = sin_q[bin_q];   op_b = v1_q[bin_q]; end
            StPRe:  begin op_a = re_q;           op_b = re_q;        end
            StPIm:  begin op_a = im_q;           op_b = im_q;        end
            default: ;
        endcase
    end

    mult_sign #(
        .W(AW)
    ) u_mult (
        .a(op_a),
        .b(op_b),
        .p(prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                s_ready = 1'b1;
                if (s_valid) state_d = StIter;
            end
            StIter: if (last_bin) state_d = last_samp ? StFRe : StIdle;
            StFRe:  state_d = StFIm;
            StFIm:  state_d = StPRe;
            StPRe:  state_d = StPIm;
            StPIm:  state_d = StOut;
            StOut: begin
                m_valid = 1'b1;
                if (m_ready) state_d = last_bin ? StIdle : StFRe;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef GOERTZEL_SAT_EN
    logic m_sat_q;
    assign m_sat = m_sat_q;
`else
    assign m_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                alpha_q[i] <= '0;
                cos_q[i]   <= '0;
                sin_q[i]   <= '0;
                v1_q[i]    <= '0;
                v2_q[i]    <= '0;
            end
            bin_q     <= '0;
            samp_q    <= '0;
            x_q       <= '0;
            re_q      <= '0;
            im_q      <= '0;
            acc_q     <= '0;
            m_power_q <= '0;
`ifdef GOERTZEL_SAT_EN
            m_sat_q   <= 1'b0;
`endif
        end else begin
            if (coef_we) begin
                alpha_q[coef_addr] <= coef_alpha;
                cos_q[coef_addr]   <= coef_cos;
                sin_q[coef_addr]   <= coef_sin;
            end
            unique case (state_q)
                StIdle: if (s_valid) x_q <= q_t'(s_data) << FB;
                StIter: begin
                    v1_q[bin_q] <= x_q + prod_q - v2_q[bin_q];
                    v2_q[bin_q] <= v1_q[bin_q];
                    if (last_bin) begin
                        bin_q <= '0;
                        if (!last_samp) samp_q <= samp_q + 1'b1;
                    end else begin
                        bin_q <= bin_q + 1'b1;
                    end
                end
                StFRe: re_q  <= prod_q - v2_q[bin_q];
                StFIm: im_q  <= prod_q;
                StPRe: acc_q <= prod;
                StPIm: begin
`ifdef GOERTZEL_SAT_EN
                    if (|pwr_sum[PW-1:IL+32]) begin
                        m_power_q <= '1;
                        m_sat_q   <= 1'b1;
                    end else begin
                        m_power_q <= pwr_sum[IL+31:IL];
                        m_sat_q   <= 1'b0;
                    end
`else
                    m_power_q <= pwr_sum[IL+31:IL];
`endif
                end
                StOut: begin
                    if (m_ready) begin
                        // Bin state restarts from zero for the next block.
                        v1_q[bin_q] <= '0;
                        v2_q[bin_q] <= '0;
                        if (last_bin) begin
                            bin_q  <= '0;
                            samp_q <= '0;
                        end else begin
                            bin_q <= bin_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_bin   = bin_q;
    assign m_power = m_power_q;

endmodule

// File: tb/tb_goertzel_multibin.sv
// Scoreboard bench for goertzel_multibin with NB=2, NS=4 and directed sample blocks.
module tb_goertzel_multibin;

    localparam int NB = 2;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam logic signed [63:0] ONE = 64'h0000_0100_0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              coef_we;
    logic [0:0]        coef_addr;
    logic signed [63:0] coef_alpha, coef_cos, coef_sin;
    logic              s_valid;
    logic              s_ready;
    logic signed [DW-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [0:0]        m_bin;
    logic [31:0]       m_power;
    logic              m_sat;

    typedef struct {
        logic [0:0]  bin;
        logic [31:0] power;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    goertzel_multibin #(
        .NB(NB),
        .NS(NS),
        .DW(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_alpha(coef_alpha),
        .coef_cos(coef_cos),
        .coef_sin(coef_sin),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_bin(m_bin),
        .m_power(m_power),
        .m_sat(m_sat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake and checks hold stability.
    logic        hold = 1'b0;
    logic [0:0]  h_bin;
    logic [31:0] h_power;
    logic        h_sat;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_m_valid", 32'(m_valid), 32'd1);
                chk("hold_m_bin", 32'(m_bin), 32'(h_bin));
                chk("hold_m_power", m_power, h_power);
                chk("hold_m_sat", 32'(m_sat), 32'(h_sat));
            end
            if (m_valid) chk("s_ready_during_out", 32'(s_ready), 32'd0);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got bin %0d power 0x%0h expected none",
                             m_bin, m_power);
                end else begin
                    e = sb.pop_front();
                    chk("m_bin", 32'(m_bin), 32'(e.bin));
                    chk("m_power", m_power, e.power);
                    chk("m_sat", 32'(m_sat), 32'(e.sat));
                end
            end
            hold    = m_valid && !m_ready;
            h_bin   = m_bin;
            h_power = m_power;
            h_sat   = m_sat;
        end
    end

    task automatic check_reset();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_bin", 32'(m_bin), 32'd0);
        chk("rst_m_power", m_power, 32'd0);
        chk("rst_m_sat", 32'(m_sat), 32'd0);
    endtask

    task automatic wr_coef(input logic [0:0] a, input logic signed [63:0] al,
                           input logic signed [63:0] c, input logic signed [63:0] s);
        coef_we = 1'b1; coef_addr = a; coef_alpha = al; coef_cos = c; coef_sin = s;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_coefs();
        wr_coef(1'b0, 2 * ONE, ONE, 64'sd0);  // DC bin
        wr_coef(1'b1, 64'sd0, 64'sd0, ONE);   // quarter-rate bin
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 m_ready = v;
        @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic send(input logic signed [31:0] x, input bit mid);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = x;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready 0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = '0;
        if (mid) begin
            chk("s_ready_iter0", 32'(s_ready), 32'd0);
            @(negedge clk);
            chk("s_ready_iter1", 32'(s_ready), 32'd0);
            @(negedge clk);
            chk("s_ready_back", 32'(s_ready), 32'd1);
        end
    endtask

    task automatic run_block(input logic signed [31:0] x0, input logic signed [31:0] x1,
                             input logic signed [31:0] x2, input logic signed [31:0] x3,
                             input logic [31:0] p0, input logic s0,
                             input logic [31:0] p1, input logic s1);
        int n;
        sb.push_back('{bin: 1'b0, power: p0, sat: s0});
        sb.push_back('{bin: 1'b1, power: p1, sat: s1});
        send(x0, 1'b1);
        send(x1, 1'b1);
        send(x2, 1'b1);
        send(x3, 1'b0);
        n = 0;
        while (m_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("first_result_latency", 32'(n), 32'(NB + 4));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sat_pw;
        logic        sat_fl;
        rst = 1'b1; coef_we = 1'b0; coef_addr = '0;
        coef_alpha = '0; coef_cos = '0; coef_sin = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset();
        load_coefs();

        // Constant input: DC bin 16, quarter-rate bin 0.
        run_block(1, 1, 1, 1, 32'd16, 1'b0, 32'd0, 1'b0);
        wait_drain();

        // Quarter-rate cosine: bin1 4, DC 0.
        run_block(1, 0, -1, 0, 32'd0, 1'b0, 32'd4, 1'b0);
        wait_drain();

        // Back-to-back identical blocks.
        run_block(1, 1, 1, 1, 32'd16, 1'b0, 32'd0, 1'b0);
        run_block(1, 1, 1, 1, 32'd16, 1'b0, 32'd0, 1'b0);
        wait_drain();

        // Back-pressure on the first result of a block.
        set_ready(1'b0);
        run_block(1, 0, -1, 0, 32'd0, 1'b0, 32'd4, 1'b0);
        repeat (10) @(negedge clk);
        chk("stall_s_ready", 32'(s_ready), 32'd0);
        set_ready(1'b1);
        wait_drain();

        // Reset mid-block discards it; coefficients must be rewritten.
        send(1, 1'b1);
        send(1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset();
        load_coefs();
        run_block(0, 1, 0, -1, 32'd0, 1'b0, 32'd4, 1'b0);  // imaginary-only bin1
        wait_drain();

        // 16*65537^2 = 2^36 + 2^21 + 16 exceeds 32 integer bits.
`ifdef GOERTZEL_SAT_EN
        sat_pw = 32'hFFFF_FFFF;
        sat_fl = 1'b1;
`else
        sat_pw = 32'h0020_0010;
        sat_fl = 1'b0;
`endif
        run_block(65537, 65537, 65537, 65537, sat_pw, sat_fl, 32'd0, 1'b0);
        wait_drain();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
